pifo_sched_ctrl: RTL
====================

PIFO_SCHED_CTRL -- requirements
Module: pifo_sched_ctrl

Interface
REQ-001 SHALL have parameter PTW, default 10: priority tag width in bits.
REQ-002 SHALL have parameter MTW, default 0: metadata width in bits; entry width EW = PTW+MTW.
REQ-003 SHALL have parameter NREQ, default 4: number of push requesters.
REQ-004 SHALL have parameter CAPACITY, default 340: maximum number of entries the PIFO holds.
REQ-005 SHALL have parameter POP_GAP, default 1: number of idle cycles forced after each PIFO pop.
REQ-006 SHALL have parameter POP_LAT, default 1: cycles from o_pifo_pop to valid i_pifo_pop_data.
REQ-007 SHALL have ports, clock and reset first:
- i_clk  in  1  sole clock, rising edge.
- i_arst_n  in  1  asynchronous active-low reset.
- i_push_req  in  NREQ  per-requester push request, held until granted.
- i_push_data  in  NREQ*EW  per-requester entry; requester k occupies bits [k*EW +: EW].
- o_push_gnt  out  NREQ  one-hot grant pulse.
- i_pop_req  in  1  level pop request.
- o_pop_ack  out  1  pulse: pop issued to the PIFO.
- o_pop_valid  out  1  pulse: o_pop_data valid.
- o_pop_data  out  EW  popped entry.
- o_pifo_push  out  1  push strobe to the PIFO.
- o_pifo_push_data  out  EW  push entry to the PIFO.
- o_pifo_pop  out  1  pop strobe to the PIFO.
- i_pifo_pop_data  in  EW  PIFO pop result.
- o_count  out  $clog2(CAPACITY+1)  current occupancy.
- o_empty, o_full  out  1 each  count==0, count==CAPACITY.

Function
REQ-008 SHALL issue at most one PIFO operation (push or pop) per cycle; o_pifo_push and o_pifo_pop never high together.
REQ-009 SHALL use an FSM with states IDLE, GAP. IDLE issues operations; a pop moves it to GAP for POP_GAP cycles, during which no operation is issued, then returns to IDLE. With POP_GAP=0, GAP is never entered.
REQ-010 SHALL, in IDLE, consider a pop eligible when i_pop_req=1 and count>0. It SHALL consider a push eligible when some unmasked i_push_req bit=1 and count<CAPACITY.
REQ-011 SHALL give the pop priority when both a pop and a push are eligible in the same cycle.
REQ-012 SHALL choose among push requesters by round-robin; after a grant to k, the next search starts at k+1 mod NREQ.
REQ-013 SHALL register its decisions: the decision made at edge N drives o_pifo_push/o_push_gnt, or o_pifo_pop/o_pop_ack, high for exactly the cycle after edge N.
- o_pifo_push_data holds the winner's i_push_data sampled at edge N.
REQ-014 SHALL exclude a requester from arbitration while its own o_push_gnt is high, so a stale request is never regranted.
REQ-015 SHALL assert o_pop_valid exactly POP_LAT cycles after o_pifo_pop, with o_pop_data = i_pifo_pop_data registered in that cycle. It SHALL use a POP_LAT-deep valid shift register.
REQ-016 SHALL update count as follows: +1 on an issued push, -1 on an issued pop, never beyond the range [0, CAPACITY].
- A push is blocked at full; pops still proceed.
- A pop is held pending at empty; pushes still proceed.
REQ-017 SHALL hold a pop request that arrives during GAP and issue it at the first IDLE cycle, provided it is still asserted.

Reset
REQ-018 SHALL, on i_arst_n=0, asynchronously force:
- FSM to IDLE and round-robin pointer to 0.
- count=0, o_empty=1, o_full=0.
- all strobes, grants, acks and valids to 0.
- o_pop_data and o_pifo_push_data to 0.
REQ-019 SHALL, on reset mid-operation, discard in-flight pop results, so no o_pop_valid appears after reset deassertion.

Configuration
REQ-020 SHALL compile statistics logic only when PIFO_SCHED_STATS_EN is defined. The logic adds outputs o_stat_push_cnt[31:0], o_stat_pop_cnt[31:0] and o_stat_hwm (occupancy high-watermark, width of o_count), all reset to 0 and wrapping at 2^32. Without the macro, these ports and registers are absent and behaviour is otherwise identical.

Structure
REQ-021 SHALL place the FSM state enum (IDLE, GAP) and the count-width function in shared package pifo_sched_pkg.
REQ-022 SHALL implement round-robin selection in sub-module pifo_sched_rr_arb (inputs: request vector, mask, advance; output: one-hot grant).

Verification
REQ-023 Reset then requester 0 pushes 10'd5 -> o_pifo_push high one cycle with data 5; o_push_gnt=4'b0001; count=1.
REQ-024 All four requesters held high continuously -> grants in order 0,1,2,3,0 on successive push cycles; no requester granted twice in a row.
REQ-025 count=3, i_pop_req and i_push_req[2] high together -> pop issued first; POP_GAP=1 idle cycle follows; push issued next; count returns to 3.
REQ-026 Pop with i_pifo_pop_data=10'd17, POP_LAT=1 -> o_pop_valid one cycle after o_pifo_pop, with o_pop_data=17.
REQ-027 CAPACITY=4: five pushes, then one pop -> the fifth push waits until after the pop; o_full=1 between; pop at count=0 stalls until a push lands.
REQ-028 Reset asserted one cycle after o_pifo_pop -> outputs zero immediately; no o_pop_valid after release.

Source files
------------

// File: rtl/pifo_sched_pkg.sv
// Shared types and sizing helpers for the PIFO scheduler controller.
package pifo_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } sched_state_t;

    // Bits needed to hold any value in [0, max_val]; never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pifo_sched_rr_arb.sv
// Round-robin selector for push requesters; search restarts after the last winner.
module pifo_sched_rr_arb
    import pifo_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_mask,
    input  logic            i_adv,
    output logic [NREQ-1:0] o_gnt
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic [PW-1:0]   idx;
    logic [NREQ-1:0] elig;
    logic            found;

    always_comb begin
        elig  = i_req & ~i_mask;
        o_gnt = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PW'((32'(ptr_q) + i) % NREQ);
            if (!found && elig[idx]) begin
                found      = 1'b1;
                o_gnt[idx] = 1'b1;
                if (i_adv) begin
                    ptr_d = PW'((32'(idx) + 1) % NREQ);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pifo_sched_ctrl.sv
// PIFO access controller: arbitrates pushes, paces pops, tracks occupancy.
// Optional statistics outputs are built only when PIFO_SCHED_STATS_EN is defined.
module pifo_sched_ctrl
    import pifo_sched_pkg::*;
#(
    parameter int unsigned PTW      = 10,
    parameter int unsigned MTW      = 0,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned CAPACITY = 340,
    parameter int unsigned POP_GAP  = 1,
    parameter int unsigned POP_LAT  = 1
) (
    input  logic                             i_clk,
    input  logic                             i_arst_n,
    input  logic [NREQ-1:0]                  i_push_req,
    input  logic [NREQ*(PTW+MTW)-1:0]        i_push_data,
    output logic [NREQ-1:0]                  o_push_gnt,
    input  logic                             i_pop_req,
    output logic                             o_pop_ack,
    output logic                             o_pop_valid,
    output logic [PTW+MTW-1:0]               o_pop_data,
    output logic                             o_pifo_push,
    output logic [PTW+MTW-1:0]               o_pifo_push_data,
    output logic                             o_pifo_pop,
    input  logic [PTW+MTW-1:0]               i_pifo_pop_data,
    output logic [cnt_w(CAPACITY)-1:0]       o_count,
    output logic                             o_empty,
    output logic                             o_full
`ifdef PIFO_SCHED_STATS_EN
    ,
    output logic [31:0]                      o_stat_push_cnt,
    output logic [31:0]                      o_stat_pop_cnt,
    output logic [cnt_w(CAPACITY)-1:0]       o_stat_hwm
`endif
);

    localparam int unsigned EW       = PTW + MTW;
    localparam int unsigned CW       = cnt_w(CAPACITY);
    localparam int unsigned GW       = cnt_w(POP_GAP);
    localparam int unsigned LAT      = (POP_LAT < 1) ? 1 : POP_LAT;
    localparam logic [CW-1:0] CAP_C  = CW'(CAPACITY);
    localparam logic [GW-1:0] GAP_LD = GW'((POP_GAP > 0) ? POP_GAP - 1 : 0);

    sched_state_t    state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_q, push_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [EW-1:0]   push_data_q, push_data_d;
    logic            pop_q, pop_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic [EW-1:0]   pop_data_q, pop_data_d;

    logic [NREQ-1:0] arb_gnt;
    logic            arb_adv;
    logic [EW-1:0]   win_data;
    logic            pop_elig;
    logic            push_elig;

    pifo_sched_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_req    (i_push_req),
        .i_mask   (gnt_q),
        .i_adv    (arb_adv),
        .o_gnt    (arb_gnt)
    );

    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) begin
                win_data = i_push_data[k*EW +: EW];
            end
        end
    end

    // Requesters still showing their grant are masked so a stale request is not regranted.
    always_comb begin
        pop_elig    = i_pop_req && (count_q != '0);
        push_elig   = (|(i_push_req & ~gnt_q)) && (count_q != CAP_C);
        state_d     = state_q;
        gap_d       = gap_q;
        count_d     = count_q;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        gnt_d       = '0;
        push_data_d = push_data_q;
        arb_adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_elig) begin
                    pop_d   = 1'b1;
                    count_d = count_q - 1'b1;
                    if (POP_GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LD;
                    end
                end else if (push_elig) begin
                    push_d      = 1'b1;
                    gnt_d       = arb_gnt;
                    arb_adv     = 1'b1;
                    count_d     = count_q + 1'b1;
                    push_data_d = win_data;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        vld_d      = (vld_q << 1) | LAT'(pop_q);
        // Result is captured on the same edge that raises the final valid stage.
        pop_data_d = vld_d[LAT-1] ? i_pifo_pop_data : pop_data_q;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            count_q     <= '0;
            push_q      <= 1'b0;
            gnt_q       <= '0;
            push_data_q <= '0;
            pop_q       <= 1'b0;
            vld_q       <= '0;
            pop_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            count_q     <= count_d;
            push_q      <= push_d;
            gnt_q       <= gnt_d;
            push_data_q <= push_data_d;
            pop_q       <= pop_d;
            vld_q       <= vld_d;
            pop_data_q  <= pop_data_d;
        end
    end

    assign o_pifo_push      = push_q;
    assign o_push_gnt       = gnt_q;
    assign o_pifo_push_data = push_data_q;
    assign o_pifo_pop       = pop_q;
    assign o_pop_ack        = pop_q;
    assign o_pop_valid      = vld_q[LAT-1];
    assign o_pop_data       = pop_data_q;
    assign o_count          = count_q;
    assign o_empty          = (count_q == '0);
    assign o_full           = (count_q == CAP_C);

`ifdef PIFO_SCHED_STATS_EN
    logic [31:0]   stat_push_q, stat_push_d;
    logic [31:0]   stat_pop_q, stat_pop_d;
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        stat_push_d = stat_push_q + {31'd0, push_d};
        stat_pop_d  = stat_pop_q + {31'd0, pop_d};
        hwm_d       = (count_d > hwm_q) ? count_d : hwm_q;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            stat_push_q <= '0;
            stat_pop_q  <= '0;
            hwm_q       <= '0;
        end else begin
            stat_push_q <= stat_push_d;
            stat_pop_q  <= stat_pop_d;
            hwm_q       <= hwm_d;
        end
    end

    assign o_stat_push_cnt = stat_push_q;
    assign o_stat_pop_cnt  = stat_pop_q;
    assign o_stat_hwm      = hwm_q;
`endif

endmodule
